instr_encoder_loader: RTL and testbench

//  Inverse of the RV32I decode path: accepts field-level instruction requests over valid/ready,

---
 rtl/instr_encoder_loader_pkg.sv | 35 +++
 rtl/instr_encoder_loader_field_packer.sv | 65 ++++++
 rtl/instr_encoder_loader.sv | 115 +++++++++++
 tb/tb_instr_encoder_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared types for the instruction encoder/loader: format codes, opcodes, error codes, FSM states.
package instr_encoder_loader_pkg;

    // Format codes match the decoder's InstructionType encoding.
    typedef enum logic [2:0] {
        FmtI = 3'd0,
        FmtS = 3'd1,
        FmtB = 3'd2,
        FmtU = 3'd3,
        FmtJ = 3'd4,
        FmtR = 3'd5
    } fmt_e;

    localparam logic [6:0] OpcOpImm = 7'b0010011;

    typedef enum logic [1:0] {
        ErrNone     = 2'b00,
        ErrRange    = 2'b01,
        ErrAlign    = 2'b10,
        ErrOverflow = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } state_e;

    // SLLI/SRLI/SRAI carry funct7 in the upper bits and a 5-bit shamt.
    function automatic logic is_shift_imm(logic [6:0] opcode, logic [2:0] funct3);
        return (opcode == OpcOpImm) && ((funct3 == 3'b001) || (funct3 == 3'b101));
    endfunction

endpackage

// File: rtl/instr_encoder_loader_field_packer.sv
// Combinational RV32I field packer with immediate range and alignment checking.
module instr_encoder_loader_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output err_e        err_o
);

    logic signed [31:0] imm_s;
    logic               shift;

    assign imm_s = $signed(imm_i);
    assign shift = is_shift_imm(opcode_i, funct3_i);

    // Pack by format; a range violation wins over a misaligned offset.
    always_comb begin
        word_o = '0;
        err_o  = ErrNone;
        case (fmt_i)
            FmtR: begin
                word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            FmtI: begin
                if (shift) begin
                    word_o = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
                    if ((imm_s < 32'sd0) || (imm_s > 32'sd31)) err_o = ErrRange;
                end else begin
                    word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                    if ((imm_s < -32'sd2048) || (imm_s > 32'sd2047)) err_o = ErrRange;
                end
            end
            FmtS: begin
                word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                if ((imm_s < -32'sd2048) || (imm_s > 32'sd2047)) err_o = ErrRange;
            end
            FmtB: begin
                word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
                if ((imm_s < -32'sd4096) || (imm_s > 32'sd4094)) err_o = ErrRange;
                else if (imm_i[0])                                err_o = ErrAlign;
            end
            FmtU: begin
                word_o = {imm_i[31:12], rd_i, opcode_i};
                if (imm_i[11:0] != 12'd0) err_o = ErrAlign;
            end
            FmtJ: begin
                word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                if ((imm_s < -32'sd1048576) || (imm_s > 32'sd1048574)) err_o = ErrRange;
                else if (imm_i[0])                                      err_o = ErrAlign;
            end
            default: begin
                err_o = ErrRange;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot/test program loader: packs field-level requests into RV32I words and streams them to IMEM.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_fmt_i,
    input  logic [6:0]        req_opcode_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [6:0]        req_funct7_i,
    input  logic [4:0]        req_rd_i,
    input  logic [4:0]        req_rs1_i,
    input  logic [4:0]        req_rs2_i,
    input  logic [31:0]       req_imm_i,
    input  logic              req_last_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [ADDR_W:0]   count_o
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);

    state_e              state_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   wr_ptr_d;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     count_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    err_e                err_code_q;
    logic [31:0]         pack_word;
    err_e                pack_err;
    logic                accept;
    logic                full;

    instr_encoder_loader_field_packer u_packer (
        .fmt_i    (req_fmt_i),
        .opcode_i (req_opcode_i),
        .funct3_i (req_funct3_i),
        .funct7_i (req_funct7_i),
        .rd_i     (req_rd_i),
        .rs1_i    (req_rs1_i),
        .rs2_i    (req_rs2_i),
        .imm_i    (req_imm_i),
        .word_o   (pack_word),
        .err_o    (pack_err)
    );

    assign req_ready_o = (state_q == StLoad) && !start_i;
    assign accept      = req_valid_i && req_ready_o;
    assign full        = (count_q == DepthCnt);
    // Pointer wraps naturally at 2**ADDR_W.
    assign wr_ptr_d    = wr_ptr_q + 1'b1;
    assign count_d     = count_q + 1'b1;

    // Session FSM, write pointer and registered IMEM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= BaseAddr;
            count_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_code_q <= ErrNone;
        end else begin
            we_q <= 1'b0;
            if (start_i) begin
                state_q    <= StLoad;
                wr_ptr_q   <= BaseAddr;
                count_q    <= '0;
                err_code_q <= ErrNone;
            end else if (accept) begin
                if (full) begin
                    state_q    <= StErr;
                    err_code_q <= ErrOverflow;
                end else if (pack_err != ErrNone) begin
                    state_q    <= StErr;
                    err_code_q <= pack_err;
                end else begin
                    we_q     <= 1'b1;
                    addr_q   <= wr_ptr_q;
                    wdata_q  <= pack_word;
                    wr_ptr_q <= wr_ptr_d;
                    count_q  <= count_d;
                    if (req_last_i) state_q <= StDone;
                end
            end
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign busy_o       = (state_q == StLoad);
    assign done_o       = (state_q == StDone);
    assign err_o        = (state_q == StErr);
    assign err_code_o   = err_code_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader against a field-level reference model.
module tb_instr_encoder_loader;

    localparam int unsigned AW   = 8;
    localparam int unsigned DEP  = 4;
    localparam int unsigned BASE = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_fmt = '0;
    logic [6:0]    req_opcode = '0;
    logic [2:0]    req_funct3 = '0;
    logic [6:0]    req_funct7 = '0;
    logic [4:0]    req_rd = '0;
    logic [4:0]    req_rs1 = '0;
    logic [4:0]    req_rs2 = '0;
    logic [31:0]   req_imm = '0;
    logic          req_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    instr_encoder_loader #(
        .ADDR_W    (AW),
        .DEPTH     (DEP),
        .BASE_ADDR (BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_fmt_i    (req_fmt),
        .req_opcode_i (req_opcode),
        .req_funct3_i (req_funct3),
        .req_funct7_i (req_funct7),
        .req_rd_i     (req_rd),
        .req_rs1_i    (req_rs1),
        .req_rs2_i    (req_rs2),
        .req_imm_i    (req_imm),
        .req_last_i   (req_last),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .err_code_o   (err_code),
        .count_o      (count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference session state, kept at the level of the behavioural description.
    bit m_open;
    bit m_done;
    bit m_err;
    int m_code;
    int m_count;

    logic        got_we;
    logic [31:0] got_addr;
    logic [31:0] got_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fld(input int v, input int hi, input int lo);
        logic [31:0] u;
        u = v;
        return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    // Encoding and legality straight from the RV32I format tables.
    function automatic void ref_encode(input int fmt, input int op, input int f3, input int f7,
                                       input int rd, input int rs1, input int rs2, input int imm,
                                       output logic [31:0] w, output int code);
        logic [31:0] mid;
        mid  = (rs1 << 15) | (f3 << 12) | op;
        w    = '0;
        code = 0;
        case (fmt)
            0: begin
                if (op == 19 && (f3 == 1 || f3 == 5)) begin
                    if (imm < 0 || imm > 31) code = 1;
                    w = (f7 << 25) | (fld(imm, 4, 0) << 20) | mid | (rd << 7);
                end else begin
                    if (imm < -2048 || imm > 2047) code = 1;
                    w = (fld(imm, 11, 0) << 20) | mid | (rd << 7);
                end
            end
            1: begin
                if (imm < -2048 || imm > 2047) code = 1;
                w = (fld(imm, 11, 5) << 25) | (rs2 << 20) | mid | (fld(imm, 4, 0) << 7);
            end
            2: begin
                if (imm < -4096 || imm > 4094) code = 1;
                else if (imm % 2 != 0)         code = 2;
                w = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (rs2 << 20) | mid
                  | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7);
            end
            3: begin
                if (fld(imm, 11, 0) != 0) code = 2;
                w = (fld(imm, 31, 12) << 12) | (rd << 7) | op;
            end
            4: begin
                if (imm < -1048576 || imm > 1048574) code = 1;
                else if (imm % 2 != 0)               code = 2;
                w = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
                  | (fld(imm, 19, 12) << 12) | (rd << 7) | op;
            end
            5: w = (f7 << 25) | (rs2 << 20) | mid | (rd << 7);
            default: code = 1;
        endcase
    endfunction

    task automatic check_status();
        check("busy", 32'(busy), 32'(m_open));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        check("err_code", 32'(err_code), 32'(m_code));
        check("count", 32'(count), 32'(m_count));
    endtask

    task automatic model_reset();
        m_open  = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_code  = 0;
        m_count = 0;
    endtask

    // Called at posedge+1; presents one request for one cycle and checks the registered result.
    task automatic send(input int fmt, input int op, input int f3, input int f7, input int rd,
                        input int rs1, input int rs2, input int imm, input bit last);
        logic [31:0] w;
        int          code;
        bit          exp_we;
        int          exp_addr;
        exp_we     = 1'b0;
        exp_addr   = 0;
        w          = '0;
        req_fmt    = 3'(fmt);
        req_opcode = 7'(op);
        req_funct3 = 3'(f3);
        req_funct7 = 7'(f7);
        req_rd     = 5'(rd);
        req_rs1    = 5'(rs1);
        req_rs2    = 5'(rs2);
        req_imm    = imm;
        req_last   = last;
        req_valid  = 1'b1;
        #1;
        check("ready", 32'(req_ready), 32'(m_open));
        @(posedge clk);
        #1;
        if (m_open) begin
            ref_encode(fmt, op, f3, f7, rd, rs1, rs2, imm, w, code);
            if (m_count == DEP) code = 3;
            if (code != 0) begin
                m_open = 1'b0;
                m_err  = 1'b1;
                m_code = code;
            end else begin
                exp_we   = 1'b1;
                exp_addr = (BASE + m_count) % (1 << AW);
                m_count++;
                if (last) begin
                    m_open = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        got_we   = imem_we;
        got_addr = 32'(imem_addr);
        got_data = imem_wdata;
        check("imem_we", 32'(imem_we), 32'(exp_we));
        if (exp_we) begin
            check("imem_addr", 32'(imem_addr), 32'(exp_addr));
            check("imem_wdata", imem_wdata, w);
        end
        check_status();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_last  = 1'b0;
        @(posedge clk);
        #1;
        check("we_idle", 32'(imem_we), 32'd0);
        check_status();
    endtask

    task automatic do_start(input bit with_valid);
        start     = 1'b1;
        req_valid = with_valid;
        #1;
        check("ready_start", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        start     = 1'b0;
        req_valid = 1'b0;
        model_reset();
        m_open = 1'b1;
        check("we_start", 32'(imem_we), 32'd0);
        check_status();
    endtask

    function automatic int rand_imm();
        int edges[18];
        edges = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4097,
                  1048574, 1048576, -1048576, -1048578, 31, 32, -1, 0, 6};
        case ($urandom % 4)
            0:       return edges[$urandom % 18];
            1:       return int'($urandom_range(0, 64)) - 32;
            2:       return int'($urandom & 32'hFFFF_F000);
            default: return int'($urandom_range(0, 8191)) - 4096;
        endcase
    endfunction

    task automatic send_random(input bit last);
        int r;
        int fmt;
        int op;
        r   = int'($urandom % 16);
        fmt = (r < 14) ? (r % 6) : (6 + (r & 1));
        op  = int'($urandom % 128);
        if (fmt == 0 && ($urandom % 2 == 0)) op = 19;
        send(fmt, op, int'($urandom % 8), int'($urandom % 128), int'($urandom % 32),
             int'($urandom % 32), int'($urandom % 32), rand_imm(), last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        model_reset();
        #3;
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check_status();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Requests in IDLE are not accepted.
        send(0, 19, 0, 0, 1, 0, 0, 5, 1'b0);
        idle();

        // ADDI x1,x0,5
        do_start(1'b0);
        send(0, 7'b0010011, 0, 0, 1, 0, 0, 5, 1'b0);
        check("addi_word", got_data, 32'h0050_0093);
        check("addi_addr", got_addr, 32'd0);
        idle();

        // SW x2,-4(x3) then BEQ x0,x0,-8 back to back
        do_start(1'b0);
        send(1, 7'b0100011, 2, 0, 0, 3, 2, -4, 1'b0);
        check("sw_word", got_data, 32'hFE21_AE23);
        send(2, 7'b1100011, 0, 0, 0, 0, 0, -8, 1'b0);
        check("beq_word", got_data, 32'hFE00_0CE3);
        check("beq_addr", got_addr, 32'd1);
        idle();

        // JAL x1,+2048 as last
        do_start(1'b0);
        send(4, 7'b1101111, 0, 0, 1, 0, 0, 2048, 1'b1);
        check("jal_word", got_data, 32'h0010_00EF);
        check("jal_done", 32'(done), 32'd1);
        check("jal_ready", 32'(req_ready), 32'd0);
        idle();

        // SRAI x5,x5,3 then shamt 32
        do_start(1'b0);
        send(0, 7'b0010011, 5, 7'b0100000, 5, 5, 0, 3, 1'b0);
        check("srai_word", got_data, 32'h4032_D293);
        send(0, 7'b0010011, 5, 7'b0100000, 5, 5, 0, 32, 1'b0);
        check("shamt_code", 32'(err_code), 32'd1);
        idle();

        // Range then alignment errors; start clears them.
        do_start(1'b0);
        send(0, 7'b0010011, 0, 0, 1, 0, 0, 2048, 1'b0);
        check("addi2048_we", 32'(got_we), 32'd0);
        check("addi2048_code", 32'(err_code), 32'd1);
        send(0, 7'b0010011, 0, 0, 1, 0, 0, 1, 1'b0);
        do_start(1'b0);
        send(2, 7'b1100011, 0, 0, 0, 0, 0, 6, 1'b0);
        send(2, 7'b1100011, 0, 0, 0, 0, 0, 7, 1'b0);
        check("beq7_code", 32'(err_code), 32'd2);
        do_start(1'b0);
        check("err_cleared", 32'(err), 32'd0);

        // Overflow at DEPTH, then restart mid-session with a pending write.
        for (int i = 0; i < 5; i++) send(5, 7'b0110011, 0, 0, i + 1, 2, 3, 0, 1'b0);
        check("ovf_code", 32'(err_code), 32'd3);
        check("ovf_count", 32'(count), 32'(DEP));
        do_start(1'b0);
        send(0, 19, 0, 0, 1, 0, 0, 1, 1'b0);
        send(0, 19, 0, 0, 2, 0, 0, 2, 1'b0);
        do_start(1'b1);
        send(0, 19, 0, 0, 3, 0, 0, 3, 1'b0);
        check("restart_addr", got_addr, 32'(BASE));

        // Async reset while a write is on the port.
        do_start(1'b0);
        send(0, 19, 0, 0, 4, 0, 0, 4, 1'b0);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_we", 32'(imem_we), 32'd0);
        check_status();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        // Random sessions.
        for (int s = 0; s < 30; s++) begin
            int n;
            do_start(bit'($urandom % 2));
            n = int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) send_random((k == n - 1) && ($urandom % 2 == 0));
            if ($urandom % 2 == 0) idle();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
